// File: rtl/rgb565_to_grayscale.sv
// RGB565 byte-stream to 8-bit luma: pairs camera bytes into pixels, then a 2-stage weighted-sum pipeline.
// Define RGB565_GRAY_ROUND_EN to round the luma to nearest instead of truncating.
module rgb565_to_grayscale #(
   parameter int unsigned HIGH_BYTE_FIRST = 1,
   parameter int unsigned COEF_R          = 77,
   parameter int unsigned COEF_G          = 150,
   parameter int unsigned COEF_B          = 29
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       frame_start,
   input  logic       data_in_valid,
   input  logic [7:0] data_in,
   output logic       data_out_valid,
   output logic [7:0] data_out,
   output logic       sync_error
);

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned PIX_W  = 16;
   localparam int unsigned SUM_W  = 16;
   localparam int unsigned ACC_W  = 18;
`ifdef RGB565_GRAY_ROUND_EN
   localparam int unsigned ROUND_ADD = 128;
`else
   localparam int unsigned ROUND_ADD = 0;
`endif

   typedef enum logic {PH0, PH1} phase_e;

   phase_e              phase_q, phase_d;
   logic [BYTE_W-1:0]   held_q, held_d;
   logic                sync_error_q, sync_error_d;
   logic [BYTE_W-1:0]   r8_q, r8_d, g8_q, g8_d, b8_q, b8_d;
   logic                s1_valid_q, s1_valid_d;
   logic [SUM_W-1:0]    sum_q, sum_d;
   logic                s2_valid_q, s2_valid_d;
   logic [BYTE_W-1:0]   data_out_q, data_out_d;
   logic                data_out_valid_q, data_out_valid_d;

   logic                pix_load_c;
   logic [PIX_W-1:0]    pix565_c;
   logic [ACC_W-1:0]    sum_c;

   // Byte pairing; frame_start overrides the phase and flags a half-built pixel.
   always_comb begin
      phase_d      = phase_q;
      held_d       = held_q;
      sync_error_d = 1'b0;
      pix_load_c   = 1'b0;
      if (frame_start) begin
         sync_error_d = (phase_q == PH1);
         if (data_in_valid) begin
            held_d  = data_in;
            phase_d = PH1;
         end else begin
            held_d  = '0;
            phase_d = PH0;
         end
      end else if (data_in_valid) begin
         if (phase_q == PH0) begin
            held_d  = data_in;
            phase_d = PH1;
         end else begin
            phase_d    = PH0;
            pix_load_c = 1'b1;
         end
      end
   end

   always_comb begin
      pix565_c = (HIGH_BYTE_FIRST != 0) ? {held_q, data_in} : {data_in, held_q};
   end

   // Stage 1: expand components to 8 bits by replicating their MSBs.
   always_comb begin
      r8_d       = r8_q;
      g8_d       = g8_q;
      b8_d       = b8_q;
      s1_valid_d = pix_load_c;
      if (pix_load_c) begin
         r8_d = {pix565_c[15:11], pix565_c[15:13]};
         g8_d = {pix565_c[10:5],  pix565_c[10:9]};
         b8_d = {pix565_c[4:0],   pix565_c[4:2]};
      end
   end

   // Stage 2: weighted sum; weights total 256 so the top byte is the luma.
   always_comb begin
      sum_c = ACC_W'(COEF_R) * ACC_W'(r8_q)
            + ACC_W'(COEF_G) * ACC_W'(g8_q)
            + ACC_W'(COEF_B) * ACC_W'(b8_q)
            + ACC_W'(ROUND_ADD);
      sum_d      = s1_valid_q ? SUM_W'(sum_c) : sum_q;
      s2_valid_d = s1_valid_q;
   end

   // Output register holds the last luma between strobes.
   always_comb begin
      data_out_d       = s2_valid_q ? sum_q[SUM_W-1:SUM_W-BYTE_W] : data_out_q;
      data_out_valid_d = s2_valid_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         phase_q          <= PH0;
         held_q           <= '0;
         sync_error_q     <= 1'b0;
         r8_q             <= '0;
         g8_q             <= '0;
         b8_q             <= '0;
         s1_valid_q       <= 1'b0;
         sum_q            <= '0;
         s2_valid_q       <= 1'b0;
         data_out_q       <= '0;
         data_out_valid_q <= 1'b0;
      end else begin
         phase_q          <= phase_d;
         held_q           <= held_d;
         sync_error_q     <= sync_error_d;
         r8_q             <= r8_d;
         g8_q             <= g8_d;
         b8_q             <= b8_d;
         s1_valid_q       <= s1_valid_d;
         sum_q            <= sum_d;
         s2_valid_q       <= s2_valid_d;
         data_out_q       <= data_out_d;
         data_out_valid_q <= data_out_valid_d;
      end
   end

   assign data_out       = data_out_q;
   assign data_out_valid = data_out_valid_q;
   assign sync_error     = sync_error_q;

endmodule

// File: tb/tb_rgb565_to_grayscale.sv
// Self-checking bench for rgb565_to_grayscale: directed cases plus random streams against a luma model.
// Honours RGB565_GRAY_ROUND_EN for the expected values.
module tb_rgb565_to_grayscale;

   localparam int unsigned HBF = 1;
   localparam int unsigned CR  = 77;
   localparam int unsigned CG  = 150;
   localparam int unsigned CB  = 29;
`ifdef RGB565_GRAY_ROUND_EN
   localparam int unsigned RND = 128;
   localparam int unsigned EXP_RED = 77, EXP_GRN = 149, EXP_BLU = 29;
`else
   localparam int unsigned RND = 0;
   localparam int unsigned EXP_RED = 76, EXP_GRN = 149, EXP_BLU = 28;
`endif
   localparam int unsigned NPIX = 3000;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       frame_start = 1'b0;
   logic       data_in_valid = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       data_out_valid;
   logic [7:0] data_out;
   logic       sync_error;

   rgb565_to_grayscale #(
      .HIGH_BYTE_FIRST(HBF), .COEF_R(CR), .COEF_G(CG), .COEF_B(CB)
   ) dut (
      .clock(clock), .reset(reset), .frame_start(frame_start),
      .data_in_valid(data_in_valid), .data_in(data_in),
      .data_out_valid(data_out_valid), .data_out(data_out), .sync_error(sync_error)
   );

   always #5 clock = ~clock;

   int unsigned cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int unsigned val;
      int unsigned due;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned out_log[$];
   int unsigned pix_list[$];
   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned n_sync = 0;
   int unsigned last_exp = 0;
   int unsigned sync_due = 32'hFFFF_FFFF;
   bit          have_first = 1'b0;
   logic [7:0]  first_b = 8'h00;

   task automatic check(input string tag, input int unsigned act, input int unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Luma straight from the arithmetic definition.
   function automatic int unsigned luma(input int unsigned pix);
      int unsigned r5 = (pix >> 11) & 31;
      int unsigned g6 = (pix >> 5) & 63;
      int unsigned b5 = pix & 31;
      int unsigned r8 = r5 * 8 + r5 / 4;
      int unsigned g8 = g6 * 4 + g6 / 16;
      int unsigned b8 = b5 * 8 + b5 / 4;
      return (CR * r8 + CG * g8 + CB * b8 + RND) / 256;
   endfunction

   function automatic int unsigned got(input int unsigned idx);
      if (idx < out_log.size()) return out_log[idx];
      return 32'hFFFF;
   endfunction

   task automatic drive(input bit fs, input bit v, input logic [7:0] d);
      logic [15:0] pix;
      @(negedge clock);
      reset = 1'b0; frame_start = fs; data_in_valid = v; data_in = d;
      if (fs) begin
         if (have_first) sync_due = cyc + 1;
         have_first = v;
         first_b    = d;
      end else if (v) begin
         if (!have_first) begin
            have_first = 1'b1;
            first_b    = d;
         end else begin
            pix = (HBF != 0) ? {first_b, d} : {d, first_b};
            exp_q.push_back('{luma(32'(pix)), cyc + 3});
            have_first = 1'b0;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 8'($urandom));
   endtask

   task automatic do_reset(input int n);
      repeat (n) begin
         @(negedge clock);
         reset = 1'b1; frame_start = 1'b0; data_in_valid = 1'b0; data_in = 8'($urandom);
         exp_q.delete();
         have_first = 1'b0;
         sync_due   = 32'hFFFF_FFFF;
      end
   endtask

   task automatic send_pix(input int unsigned pix);
      drive(1'b0, 1'b1, 8'(pix >> 8));
      drive(1'b0, 1'b1, 8'(pix));
   endtask

   // Output monitor, sampled just after each rising edge.
   always @(posedge clock) begin
      exp_t e;
      #1;
      if (reset) begin
         check("rst_data_out", 32'(data_out), 0);
         check("rst_valid", 32'(data_out_valid), 0);
         check("rst_sync_error", 32'(sync_error), 0);
         last_exp = 0;
      end else begin
         while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            check("late_pixel", cyc, exp_q[0].due);
            void'(exp_q.pop_front());
         end
         if (data_out_valid) begin
            out_log.push_back(32'(data_out));
            if (exp_q.size() == 0) begin
               check("unexpected_valid", 32'(data_out_valid), 0);
            end else begin
               e = exp_q.pop_front();
               check("pix_value", 32'(data_out), e.val);
               check("pix_latency", cyc, e.due);
               last_exp = e.val;
            end
         end else if (cyc % 8 == 0) begin
            check("hold", 32'(data_out), last_exp);
         end
         if (sync_error) n_sync++;
         if (sync_error || cyc == sync_due)
            check("sync_error", 32'(sync_error), 32'(cyc == sync_due));
      end
   end

   initial begin
      int unsigned n0, s0, b;
      do_reset(3);

      // White then black
      n0 = out_log.size();
      drive(1'b0, 1'b1, 8'hFF); drive(1'b0, 1'b1, 8'hFF);
      drive(1'b0, 1'b1, 8'h00); drive(1'b0, 1'b1, 8'h00);
      idle(5);
      check("t1_count", out_log.size() - n0, 2);
      check("t1_white", got(n0), 255);
      check("t1_black", got(n0 + 1), 0);

      // Pure primaries
      n0 = out_log.size();
      send_pix(16'hF800); send_pix(16'h07E0); send_pix(16'h001F);
      idle(5);
      check("t2_count", out_log.size() - n0, 3);
      check("t2_red", got(n0), EXP_RED);
      check("t2_green", got(n0 + 1), EXP_GRN);
      check("t2_blue", got(n0 + 2), EXP_BLU);

      // frame_start with a half pixel held
      n0 = out_log.size(); s0 = n_sync;
      drive(1'b0, 1'b1, 8'hF8);
      drive(1'b1, 1'b1, 8'h07);
      drive(1'b0, 1'b1, 8'hE0);
      idle(5);
      check("t5_count", out_log.size() - n0, 1);
      check("t5_value", got(n0), 149);
      check("t5_sync_pulses", n_sync - s0, 1);

      // frame_start in PH0 is not an error
      s0 = n_sync;
      drive(1'b1, 1'b0, 8'h00);
      idle(3);
      check("t5_ph0_no_sync", n_sync - s0, 0);

      // Back-to-back random pixels
      n0 = out_log.size();
      for (int i = 0; i < NPIX; i++) begin
         pix_list.push_back($urandom_range(16'hFFFF));
         send_pix(pix_list[i]);
      end
      idle(5);
      check("t3_count", out_log.size() - n0, NPIX);

      // Same pixels with roughly 1-in-3 valid duty
      b = out_log.size();
      for (int i = 0; i < NPIX; i++) begin
         while ($urandom_range(2) != 0) idle(1);
         drive(1'b0, 1'b1, 8'(pix_list[i] >> 8));
         while ($urandom_range(2) != 0) idle(1);
         drive(1'b0, 1'b1, 8'(pix_list[i]));
      end
      idle(5);
      check("t4_count", out_log.size() - b, NPIX);
      for (int i = 0; i < NPIX; i += 97)
         check("t4_seq", got(b + 32'(i)), luma(pix_list[i]));

      // Reset between the bytes of a pixel
      n0 = out_log.size();
      drive(1'b0, 1'b1, 8'hAB);
      do_reset(2);
      drive(1'b0, 1'b1, 8'hCD);
      idle(5);
      check("t6_no_output_half", out_log.size() - n0, 0);
      drive(1'b0, 1'b1, 8'hEF);
      idle(5);
      check("t6_count_pair", out_log.size() - n0, 1);
      check("t6_value", got(n0), luma(32'hCDEF));

      // Reset with pixels in the pipeline
      n0 = out_log.size();
      send_pix(16'hFFFF); send_pix(16'hF800);
      do_reset(2);
      idle(6);
      check("t6_flush_count", out_log.size() - n0, 1);

      // Random mix of gaps, frame_start and occasional reset
      for (int i = 0; i < 4000; i++) begin
         int unsigned r;
         r = $urandom_range(199);
         if (r == 0) do_reset(1);
         else drive(r < 8, 1'($urandom_range(1)), 8'($urandom));
      end
      idle(6);
      check("drain_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
